// File: rtl/addsub_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
// Saturation limits are constant functions so any operand width up to 64 bits can use them.
package addsub_pkg;

    localparam int SLICE_W = 4;

    typedef struct packed {
        logic sub;
        logic sat;
    } op_mode_t;

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-lookahead slice.
// Exports group propagate and generate so the enclosing stage can build its own lookahead carries.
module cla_slice4
    import addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] Sum,
    output logic               Cout,
    output logic               PG,
    output logic               GG
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = A ^ B;
    assign g = A & B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

    assign PG   = &p;
    assign GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign c[4] = GG | (PG & Cin);

    assign Sum  = p ^ c[SLICE_W-1:0];
    assign Cout = c[4];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with optional signed saturation and N/Z/V/C flags.
// Each stage resolves WIDTH/STAGES result bits and hands its carry to the next stage through a register.
module pipe_cla_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             neg,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int NSL  = CW / SLICE_W;
    localparam int NSLT = WIDTH / SLICE_W;

    localparam logic [WIDTH-1:0] LOW_ONES = WIDTH'({CW{1'b1}});
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(sat_min(WIDTH));

    // Handshake: a beat moves on every rising edge where valid & ready are both high.
    // Stage k advances when empty or when stage k+1 advances; the last stage advances on out_ready.
    // in_ready is stage 0's advance, so it is combinational from out_ready through the chain.
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] adv;

    // Stage k combinational inputs and results
    logic [STAGES-1:0][WIDTH-1:0] st_a;
    logic [STAGES-1:0][WIDTH-1:0] st_b;
    logic [STAGES-1:0][WIDTH-1:0] st_s;
    logic [STAGES-1:0]            st_c;
    op_mode_t [STAGES-1:0]        st_m;
    logic [STAGES-1:0][WIDTH-1:0] nx_s;
    logic [STAGES-1:0]            nx_c;

    logic [WIDTH-1:0] ssum;
    logic [NSLT-1:0]  scin;
    logic [NSLT-1:0]  spg;
    logic [NSLT-1:0]  sgg;
    logic [NSLT-1:0]  unused_cout;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovfl_q;
    logic             neg_q;
    logic             zero_q;

    // Subtraction is A + ~B + 1: invert B once here and seed the stage-0 carry with 1.
    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_c[0] = sub;
    assign st_s[0] = '0;
    assign st_m[0] = {sub, sat};

    if (STAGES == 1) begin : g_vin1
        assign v_in = in_valid;
    end else begin : g_vinn
        assign v_in = {v[STAGES-2:0], in_valid};
    end

    always_comb begin
        logic full;
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full = full & v[j];
            end
            adv[k] = out_ready | ~full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v_in[k];
                end
            end
        end
    end

    // Lookahead carry into every slice, built only from slice PG/GG and the stage carry-in.
    always_comb begin
        logic c;
        scin = '0;
        for (int i = 0; i < NSLT; i++) begin
            c = st_c[i / NSL];
            for (int m = (i / NSL) * NSL; m < i; m++) begin
                c = sgg[m] | (spg[m] & c);
            end
            scin[i] = c;
        end
    end

    for (genvar i = 0; i < NSLT; i++) begin : g_slice
        localparam int K = i / NSL;
        cla_slice4 u_slice (
            .A   (st_a[K][i*SLICE_W +: SLICE_W]),
            .B   (st_b[K][i*SLICE_W +: SLICE_W]),
            .Cin (scin[i]),
            .Sum (ssum[i*SLICE_W +: SLICE_W]),
            .Cout(unused_cout[i]),
            .PG  (spg[i]),
            .GG  (sgg[i])
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] CHUNK_M = LOW_ONES << (k * CW);
        localparam logic [WIDTH-1:0] DONE_M  = (WIDTH'(1) << (k * CW)) - WIDTH'(1);
        localparam int               TOP     = (k + 1) * NSL - 1;

        // Keep low bits finished by earlier stages, insert this stage's chunk
        assign nx_s[k] = (st_s[k] & DONE_M) | (ssum & CHUNK_M);
        assign nx_c[k] = sgg[TOP] | (spg[TOP] & scin[TOP]);

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic [WIDTH-1:0] rs;
            logic             rc;
            op_mode_t         rm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                    rs <= '0;
                    rc <= 1'b0;
                    rm <= '0;
                end else if (adv[k] && v_in[k]) begin
                    ra <= st_a[k];
                    rb <= st_b[k];
                    rs <= nx_s[k];
                    rc <= nx_c[k];
                    rm <= st_m[k];
                end
            end

            assign st_a[k+1] = ra;
            assign st_b[k+1] = rb;
            assign st_s[k+1] = rs;
            assign st_c[k+1] = rc;
            assign st_m[k+1] = rm;
        end
    end

    // Final stage: overflow from the raw result, then optional clamp and flags
    logic [WIDTH-1:0] raw;
    logic             a_msb;
    logic             raw_ovfl;
    logic             do_sat;
    logic [WIDTH-1:0] fin;
    logic [2*WIDTH+1:0] unused_tail;

    assign raw      = nx_s[STAGES-1];
    assign a_msb    = st_a[STAGES-1][WIDTH-1];
    assign raw_ovfl = (a_msb ~^ st_b[STAGES-1][WIDTH-1]) & (raw[WIDTH-1] ^ a_msb);
    assign do_sat   = (SAT_EN != 0) && st_m[STAGES-1].sat && raw_ovfl;
    assign fin      = do_sat ? (a_msb ? MIN_VAL : MAX_VAL) : raw;
    assign unused_tail = {st_a[STAGES-1], st_b[STAGES-1], st_m[STAGES-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovfl_q <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv[STAGES-1] && v_in[STAGES-1]) begin
            sum_q  <= fin;
            cout_q <= nx_c[STAGES-1];
            ovfl_q <= raw_ovfl;
            neg_q  <= fin[WIDTH-1];
            zero_q <= (fin == '0);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovfl      = ovfl_q;
    assign neg       = neg_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Directed bench for pipe_cla_addsub (WIDTH=16, STAGES=2, SAT_EN=1).
// Expected results are hand-computed and queued in issue order; a monitor pops one per output transfer.
module tb_pipe_cla_addsub;

    localparam int W  = 16;
    localparam int EW = W + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         neg;
    logic         zero;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    int            fire_q[$];

    pipe_cla_addsub #(.WIDTH(W), .STAGES(2), .SAT_EN(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .sat      (sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovfl     (ovfl),
        .neg      (neg),
        .zero     (zero)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [EW-1:0] ex(input logic [W-1:0] s, input logic c, input logic v,
                                         input logic n, input logic z);
        return {s, c, v, n, z};
    endfunction

    function automatic logic [EW-1:0] observed();
        return {sum, cout, ovfl, neg, zero};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(observed()), 32'h0);
            end else begin
                check("result", 32'(observed()), 32'(exp_q.pop_front()));
                fire_q.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                              input logic tsat, input logic [EW-1:0] e);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        sat      = tsat;
        in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'h1);
            in_valid = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic tsat, input logic [EW-1:0] e);
        drive_beat(ta, tb_v, ts, tsat, e);
        wait_accept();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_outputs", 32'(observed()), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // 1: positive overflow, wrap then clamp; latency measured on the first beat
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, ex(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0));
        idle();
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'd2);
        wait_drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, ex(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
        // 2: negative overflow on subtract, clamp then wrap
        send(16'h8000, 16'h0001, 1'b1, 1'b1, ex(16'h8000, 1'b1, 1'b1, 1'b1, 1'b0));
        send(16'h8000, 16'h0001, 1'b1, 1'b0, ex(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0));
        // 3: carries crossing the stage boundary
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, ex(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
        send(16'h0005, 16'h0005, 1'b1, 1'b0, ex(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
        idle();
        wait_drain();

        // 4: back-to-back with mixed modes
        fire_q.delete();
        drive_beat(16'h1234, 16'h1111, 1'b0, 1'b0, ex(16'h2345, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk); check("b2b_ready0", 32'(in_ready), 32'h1); @(posedge clk); #1;
        drive_beat(16'h1000, 16'h2000, 1'b1, 1'b1, ex(16'hF000, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge clk); check("b2b_ready1", 32'(in_ready), 32'h1); @(posedge clk); #1;
        drive_beat(16'h00FF, 16'h0F01, 1'b0, 1'b0, ex(16'h1000, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk); check("b2b_ready2", 32'(in_ready), 32'h1); @(posedge clk); #1;
        drive_beat(16'h8000, 16'h8000, 1'b0, 1'b1, ex(16'h8000, 1'b1, 1'b1, 1'b1, 1'b0));
        @(negedge clk); check("b2b_ready3", 32'(in_ready), 32'h1); @(posedge clk); #1;
        idle();
        wait_drain();
        check("b2b_count", 32'(fire_q.size()), 32'd4);
        for (int i = 0; i + 1 < fire_q.size(); i++) begin
            check("b2b_gap", 32'(fire_q[i+1] - fire_q[i]), 32'd1);
        end

        // 5: consumer stall fills the pipe and back-pressures the producer
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 1'b0, ex(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'h0010, 16'h0020, 1'b0, 1'b0, ex(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0));
        drive_beat(16'h0100, 16'h0200, 1'b0, 1'b0, ex(16'h0300, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_sum", 32'(sum), 32'h0003);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept();
        send(16'h0003, 16'h0004, 1'b1, 1'b0, ex(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        send(16'h4000, 16'h4000, 1'b0, 1'b0, ex(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0));
        idle();
        wait_drain();

        // 6: asynchronous reset with beats in flight
        out_ready = 1'b0;
        send(16'h0011, 16'h0022, 1'b0, 1'b0, ex(16'h0033, 1'b0, 1'b0, 1'b0, 1'b0));
        send(16'h0100, 16'h0001, 1'b0, 1'b0, ex(16'h0101, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_outputs", 32'(observed()), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no_stale_after_reset", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        send(16'h0002, 16'h0003, 1'b0, 1'b0, ex(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0));
        idle();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
